// File: rtl/me_pkg.sv
// Shared types for the motion-estimation frame loader.
// Holds the FSM state enum, default memory depths and the result record.
package me_pkg;

   localparam int R_DEPTH_DEF = 256;
   localparam int S_DEPTH_DEF = 1024;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_R = 3'd1,
      LOAD_S = 3'd2,
      KICK   = 3'd3,
      WAIT   = 3'd4,
      RESULT = 3'd5
   } state_t;

   typedef struct packed {
      logic       timeout_err;
      logic [7:0] frame_id;
      logic [7:0] best_dist;
      logic [3:0] motion_x;
      logic [3:0] motion_y;
   } result_t;

endpackage

// File: rtl/frame_loader.sv
// Streams R then S pixel bytes into two memories, kicks the ME core,
// waits (with timeout) for its result and offers it as a record.
// Ports: clock/reset; in_data/in_valid/in_ready byte stream;
//   wr_*_r / wr_*_s memory write ports; start/completed/motionX/motionY/
//   BestDist core handshake; res_valid/res_ready/res_data result record.
module frame_loader
   import me_pkg::*;
#(
   parameter int R_DEPTH = R_DEPTH_DEF,
   parameter int S_DEPTH = S_DEPTH_DEF,
   parameter int TIMEOUT = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        wr_en_r,
   output logic [7:0]  wr_addr_r,
   output logic [7:0]  wr_data_r,
   output logic        wr_en_s,
   output logic [9:0]  wr_addr_s,
   output logic [7:0]  wr_data_s,
   output logic        start,
   input  logic        completed,
   input  logic [3:0]  motionX,
   input  logic [3:0]  motionY,
   input  logic [7:0]  BestDist,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [24:0] res_data
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state;
   logic [9:0]    cnt;
   logic [TW-1:0] tcnt;
   logic [7:0]    frame_id;
   result_t       res;

   logic loading_r;
   logic loading_s;
   logic accept;
   logic r_last;
   logic s_last;
   logic done_seen;
   logic timed_out;

   // IDLE takes the first R byte so the stream never stalls on entry.
   assign loading_r = (state == IDLE) || (state == LOAD_R);
   assign loading_s = (state == LOAD_S);

   // Gated by reset so the stream is refused while reset is held.
   assign in_ready  = reset && (loading_r || loading_s);
   assign accept    = in_valid && in_ready;

   assign r_last    = (cnt == 10'(R_DEPTH - 1));
   assign s_last    = (cnt == 10'(S_DEPTH - 1));

   assign wr_en_r   = accept && loading_r;
   assign wr_addr_r = loading_r ? cnt[7:0] : '0;
   assign wr_data_r = wr_en_r ? in_data : '0;

   assign wr_en_s   = accept && loading_s;
   assign wr_addr_s = loading_s ? cnt : '0;
   assign wr_data_s = wr_en_s ? in_data : '0;

   assign start     = (state == KICK);
   assign res_valid = (state == RESULT);
   assign res_data  = res;

   // The first WAIT cycle may still see a stale done level from the
   // previous job, so completed is only trusted from the second one on.
   assign done_seen = completed && (tcnt != '0);
   assign timed_out = (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         tcnt     <= '0;
         frame_id <= '0;
         res      <= '0;
      end else begin
         unique case (state)
            IDLE, LOAD_R: begin
               if (accept) begin
                  if (r_last) begin
                     cnt   <= '0;
                     state <= LOAD_S;
                  end else begin
                     cnt   <= cnt + 10'd1;
                     state <= LOAD_R;
                  end
               end
            end
            LOAD_S: begin
               if (accept) begin
                  if (s_last) begin
                     cnt   <= '0;
                     state <= KICK;
                  end else begin
                     cnt   <= cnt + 10'd1;
                  end
               end
            end
            KICK: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (done_seen) begin
                  res   <= {1'b0, frame_id, BestDist, motionX, motionY};
                  state <= RESULT;
               end else if (timed_out) begin
                  res   <= {1'b1, frame_id, 16'h0000};
                  state <= RESULT;
               end else begin
                  tcnt  <= tcnt + 1'b1;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  frame_id <= frame_id + 8'd1;
                  tcnt     <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: table-driven stream start plus
// hand-written sequences for result, backpressure, timeout and reset.
module tb_frame_loader;

   localparam int R = 256;
   localparam int S = 1024;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en_r;
   logic [7:0]  wr_addr_r;
   logic [7:0]  wr_data_r;
   logic        wr_en_s;
   logic [9:0]  wr_addr_s;
   logic [7:0]  wr_data_s;
   logic        start;
   logic        completed;
   logic [3:0]  motionX;
   logic [3:0]  motionY;
   logic [7:0]  BestDist;
   logic        res_valid;
   logic        res_ready;
   logic [24:0] res_data;

   frame_loader dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wr_en_r   (wr_en_r),
      .wr_addr_r (wr_addr_r),
      .wr_data_r (wr_data_r),
      .wr_en_s   (wr_en_s),
      .wr_addr_s (wr_addr_s),
      .wr_data_s (wr_data_s),
      .start     (start),
      .completed (completed),
      .motionX   (motionX),
      .motionY   (motionY),
      .BestDist  (BestDist),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       rdy;
      logic       en_r;
      logic [7:0] addr;
   } vec_t;

   vec_t       tv [7];
   int         n_pass = 0;
   int         n_total = 0;
   int         seq_err;
   logic [7:0] mr [R];
   logic [7:0] ms [S];
   int         cr [R];
   int         cs [S];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] bval(input int i, input int seed);
      return 8'(i * 13 + seed);
   endfunction

   task automatic clear_mem();
      for (int a = 0; a < R; a++) begin mr[a] = 'x; cr[a] = 0; end
      for (int a = 0; a < S; a++) begin ms[a] = 'x; cs[a] = 0; end
      seq_err = 0;
   endtask

   task automatic note_writes();
      if (wr_en_r) begin mr[wr_addr_r] = wr_data_r; cr[wr_addr_r]++; end
      if (wr_en_s) begin ms[wr_addr_s] = wr_data_s; cs[wr_addr_s]++; end
   endtask

   // Feeds stream bytes [from, upto); returns at the cycle after the last.
   task automatic feed(input int from, input int upto, input bit gapped,
                       input int seed);
      for (int i = from; i < upto; i++) begin
         if (gapped) begin
            in_valid = 1'b0;
            #1;
            if (wr_en_r || wr_en_s || !in_ready || start) seq_err++;
            tick();
         end
         in_valid = 1'b1;
         in_data  = bval(i, seed);
         #1;
         if (!in_ready || start || (wr_en_r && wr_en_s)) seq_err++;
         if (i < R) begin
            if (!wr_en_r || wr_addr_r != 8'(i) || wr_data_r != in_data)
               seq_err++;
         end else begin
            if (!wr_en_s || wr_addr_s != 10'(i - R) || wr_data_s != in_data)
               seq_err++;
         end
         note_writes();
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic check_mem(input int seed, input string name);
      int errs;
      errs = 0;
      for (int a = 0; a < R; a++)
         if (mr[a] !== bval(a, seed) || cr[a] != 1) errs++;
      for (int a = 0; a < S; a++)
         if (ms[a] !== bval(R + a, seed) || cs[a] != 1) errs++;
      check({name, "_mem"}, errs, 0);
      check({name, "_seq"}, seq_err, 0);
   endtask

   task automatic wait_res(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
         #1;
      end while (!res_valid && n < max);
   endtask

   task automatic handshake(input string name);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      check({name, "_hs_valid"}, res_valid, 0);
      check({name, "_hs_ready"}, in_ready, 1);
   endtask

   initial begin
      int n;
      int errs;
      logic [24:0] held;

      tv[0] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd0};
      tv[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'd0};
      tv[2] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd1};
      tv[3] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd1};
      tv[4] = '{1'b1, 8'h0D, 1'b1, 1'b1, 8'd1};
      tv[5] = '{1'b1, 8'h1A, 1'b1, 1'b1, 8'd2};
      tv[6] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd3};

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      completed = 1'b0;
      motionX   = 4'd0;
      motionY   = 4'd0;
      BestDist  = 8'd0;
      res_ready = 1'b0;
      clear_mem();
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_start", start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_wr_en", {wr_en_r, wr_en_s}, 0);
      reset = 1'b1;
      tick();

      // Run 1: table-driven start, continuous remainder, normal result.
      for (int k = 0; k < 7; k++) begin
         in_valid = tv[k].v;
         in_data  = tv[k].d;
         #1;
         check($sformatf("tv%0d_ready", k), in_ready, tv[k].rdy);
         check($sformatf("tv%0d_en_r", k), wr_en_r, tv[k].en_r);
         check($sformatf("tv%0d_addr", k), wr_addr_r, tv[k].addr);
         note_writes();
         tick();
      end
      feed(3, R + S, 1'b0, 0);
      #1;
      check("r1_start", start, 1);
      check("r1_kick_ready", in_ready, 0);
      check_mem(0, "r1");
      repeat (20) tick();
      completed = 1'b1;
      motionX   = 4'd3;
      motionY   = 4'd12;
      BestDist  = 8'h2A;
      n = 20;
      do begin
         tick();
         n++;
         #1;
      end while (!res_valid && n < 60);
      completed = 1'b0;
      check("r1_res_valid", res_valid, 1);
      check("r1_latency", n, 21);
      check("r1_res_data", res_data, 25'h002A3C);
      held = 25'h002A3C;
      errs = 0;
      for (int k = 0; k < 10; k++) begin
         if (!res_valid || res_data !== held || in_ready) errs++;
         tick();
         #1;
      end
      check("r1_backpressure", errs, 0);
      handshake("r1");

      // Run 2: 50% gapped stream, completed held high from KICK.
      clear_mem();
      feed(0, R + S, 1'b1, 5);
      #1;
      check("r2_start", start, 1);
      check_mem(5, "r2");
      completed = 1'b1;
      motionX   = 4'd5;
      motionY   = 4'd9;
      BestDist  = 8'h77;
      tick();
      check("r2_start_pulse", start, 0);
      check("r2_wait1", res_valid, 0);
      tick();
      check("r2_wait2", res_valid, 0);
      tick();
      completed = 1'b0;
      check("r2_res_valid", res_valid, 1);
      check("r2_res_data", res_data, 25'h017759);
      handshake("r2");

      // Run 3: continuous stream, completed never raised -> timeout.
      clear_mem();
      in_valid = 1'b1;
      in_data  = bval(0, 9);
      #1;
      check("r3_first_en", wr_en_r, 1);
      feed(0, R + S, 1'b0, 9);
      #1;
      check("r3_start_1280", start, 1);
      check_mem(9, "r3");
      motionX  = 4'hF;
      motionY  = 4'hE;
      BestDist = 8'hDD;
      errs = 0;
      for (int k = 0; k < 4096; k++) begin
         tick();
         if (res_valid || start) errs++;
      end
      check("r3_no_early_res", errs, 0);
      tick();
      check("r3_res_valid", res_valid, 1);
      check("r3_res_data", res_data, 25'h1020000);
      handshake("r3");

      // Run 4: reset in LOAD_S at S address 500, then a fresh run.
      clear_mem();
      feed(0, R + 500, 1'b0, 3);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      #1;
      check("r4_pre_addr_s", wr_addr_s, 500);
      reset = 1'b0;
      #1;
      check("r4_rst_ready", in_ready, 0);
      check("r4_rst_wr_en", {wr_en_r, wr_en_s}, 0);
      check("r4_rst_addr", {wr_addr_r, wr_addr_s}, 0);
      check("r4_rst_outs", {start, res_valid, res_data}, 0);
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      clear_mem();
      feed(0, R + S, 1'b0, 7);
      #1;
      check("r4_start", start, 1);
      check_mem(7, "r4");
      repeat (3) tick();
      completed = 1'b1;
      motionX   = 4'd1;
      motionY   = 4'd2;
      BestDist  = 8'h10;
      wait_res(50, n);
      completed = 1'b0;
      check("r4_res_valid", res_valid, 1);
      check("r4_res_data", res_data, 25'h001012);
      handshake("r4");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
